// File: rtl/bnn_feature_sequencer.sv
// rtl/bnn_feature_sequencer.sv - serial feature packer and result sequencer for sequential BNN wrappers
module bnn_feature_sequencer #(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6,
  parameter int LATENCY   = 48,
  localparam int CLS_W    = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [CLS_W-1:0]              bnn_prediction,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CLS_W-1:0]              m_class,
  output logic                          m_error,
  output logic                          busy
);

  localparam int FW    = FEAT_CNT * FEAT_BITS;
  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FEAT_CNT - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(LATENCY - 1);
  localparam logic [31:0]      CLASS_LIM = 32'(CLASS_CNT);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [FW-1:0]    shadow;
  logic [FW-1:0]    shadow_nxt;
  logic             beat_acc;
  logic             last_beat;
  logic             wait_done;
  logic             pred_err;

  // Handshake qualifiers and out-of-range detection for the sampled class
  always_comb begin
    beat_acc  = s_valid && s_ready;
    last_beat = beat_acc && (idx == LAST_IDX);
    wait_done = (state == ST_WAIT) && (cnt == LAST_CNT);
    pred_err  = ({{(32-CLS_W){1'b0}}, bnn_prediction} >= CLASS_LIM);
  end

  // Shadow frame with the current beat merged into slot idx
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < FEAT_CNT; i++) begin
      if (idx == IDX_W'(i)) begin
        shadow_nxt[i*FEAT_BITS +: FEAT_BITS] = s_data;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: load a frame, wait out the BNN latency, hold result until taken
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (last_beat) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == LAST_CNT) state_nxt = ST_OUT;
      ST_OUT:  if (m_ready) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Stream flags; s_ready is gated by reset so nothing is taken while held
  always_comb begin
    s_ready = (state == ST_LOAD) && rst;
    m_valid = (state == ST_OUT);
    busy    = (state != ST_LOAD);
  end

  // Beat packing, latency counting and prediction capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      cnt      <= '0;
      shadow   <= '0;
      features <= '0;
      m_class  <= '0;
      m_error  <= 1'b0;
    end else begin
      if (beat_acc) begin
        shadow <= shadow_nxt;
        if (last_beat) begin
          idx      <= '0;
          cnt      <= '0;
          features <= shadow_nxt;
        end else begin
          idx <= idx + 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (wait_done) begin
        m_class <= bnn_prediction;
        m_error <= pred_err;
      end
    end
  end

endmodule

// File: tb/tb_bnn_feature_sequencer.sv
// tb/tb_bnn_feature_sequencer.sv - scoreboard bench for bnn_feature_sequencer
module tb_bnn_feature_sequencer;

  localparam int FEAT_CNT  = 11;
  localparam int FEAT_BITS = 4;
  localparam int CLASS_CNT = 6;
  localparam int LATENCY   = 48;
  localparam int CLS_W     = 3;
  localparam int FW        = FEAT_CNT * FEAT_BITS;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [FEAT_BITS-1:0] s_data;
  logic [FW-1:0]    features;
  logic [CLS_W-1:0] bnn_prediction;
  logic             m_valid;
  logic             m_ready;
  logic [CLS_W-1:0] m_class;
  logic             m_error;
  logic             busy;

  bnn_feature_sequencer #(
    .FEAT_CNT (FEAT_CNT),
    .FEAT_BITS(FEAT_BITS),
    .CLASS_CNT(CLASS_CNT),
    .LATENCY  (LATENCY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .features      (features),
    .bnn_prediction(bnn_prediction),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_class       (m_class),
    .m_error       (m_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FW-1:0]    feat;
    logic [CLS_W-1:0] cls;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int tb_idx = 0;
  int complete_edge = -1000;
  int sample_edge = -1000;
  int hs_edge = -1;
  int pulses = 0;
  int hi_cycles = 0;
  logic prev_mv = 1'b0;
  logic [CLS_W-1:0] cur_pred = '0;
  logic [CLS_W-1:0] frame_pred = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [FW-1:0] f, input logic [CLS_W-1:0] c, input logic e);
    exp_t x;
    x.feat = f;
    x.cls  = c;
    x.err  = e;
    exp_q.push_back(x);
  endtask

  // Edge counter: at a negedge, cyc is the number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  // BNN model: the right prediction only in the cycle leading into the sampling edge, a decoy otherwise
  always @(negedge clk) begin
    if (!rst) begin
      tb_idx = 0;
      complete_edge = -1000;
      sample_edge = -1000;
    end else begin
      if (s_valid && s_ready) begin
        if (tb_idx == FEAT_CNT - 1) begin
          tb_idx = 0;
          complete_edge = cyc + 1;
          sample_edge = cyc + 1 + LATENCY;
          frame_pred = cur_pred;
        end else begin
          tb_idx++;
        end
      end
      if (m_valid && m_ready) hs_edge = cyc + 1;
    end
    bnn_prediction = (cyc + 1 == sample_edge) ? frame_pred : ~frame_pred;
  end

  // Monitor: checks the frame load and pops one expected result per m_valid rise
  always @(negedge clk) begin
    if (rst) begin
      if (cyc == complete_edge) begin
        if (exp_q.size() != 0) chk("features_load", features, exp_q[0].feat);
        else chk("exp_pending", exp_q.size(), 1);
        chk("busy_in_wait", busy, 1'b1);
      end
      if (m_valid && !prev_mv) begin
        pulses++;
        chk("result_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("latency", cyc, complete_edge + LATENCY);
          chk("m_class", m_class, mon_e.cls);
          chk("m_error", m_error, mon_e.err);
          chk("features_at_result", features, mon_e.feat);
        end
      end
      if (m_valid) hi_cycles++;
    end
    prev_mv = m_valid;
  end

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FW-1:0] beats, input bit gapped, input bit chk_zero,
                            output int first_edge);
    first_edge = -1;
    for (int i = 0; i < FEAT_CNT; i++) begin
      int guard;
      guard = 0;
      s_valid = 1'b1;
      s_data = beats[i*FEAT_BITS +: FEAT_BITS];
      do begin
        @(negedge clk);
        guard++;
      end while (!s_ready && guard < 300);
      if (!s_ready) chk("beat_accept", s_ready, 1'b1);
      if (i == 0) first_edge = cyc + 1;
      if (chk_zero && i == FEAT_CNT - 1) chk("features_hold_zero", features, '0);
      @(posedge clk);
      #1;
      if (gapped) begin
        s_valid = 1'b0;
        s_data = 4'hA;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((m_valid || exp_q.size() != 0) && g < 300);
    chk("idle_reached", (m_valid || exp_q.size() != 0), 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int fe;
    int fb;
    int g;
    rst = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_features", features, '0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_class", m_class, '0);
    chk("rst_m_error", m_error, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("s_ready_after_rst", s_ready, 1'b1);

    // Basic frame on consecutive cycles
    m_ready = 1'b1;
    cur_pred = 3'd3;
    push_exp(44'hBA987654321, 3'd3, 1'b0);
    send_frame(44'hBA987654321, 1'b0, 1'b0, fe);
    wait_idle();

    // Gapped beats from a fresh reset
    do_reset();
    cur_pred = 3'd5;
    push_exp(44'hBA987654321, 3'd5, 1'b0);
    send_frame(44'hBA987654321, 1'b1, 1'b1, fe);
    wait_idle();

    // Back-pressure with an out-of-range prediction
    m_ready = 1'b0;
    cur_pred = 3'd7;
    push_exp(44'h56789ABCDEF, 3'd7, 1'b1);
    send_frame(44'h56789ABCDEF, 1'b0, 1'b0, fe);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!m_valid && g < 200);
    chk("bp_m_valid_seen", m_valid, 1'b1);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data = 4'h0;
    repeat (20) begin
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1'b1);
      chk("bp_m_class", m_class, 3'd7);
      chk("bp_m_error", m_error, 1'b1);
      chk("bp_features", features, 44'h56789ABCDEF);
      chk("bp_s_ready", s_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_m_valid", m_valid, 1'b0);
    chk("bp_release_s_ready", s_ready, 1'b1);

    // Reset ten cycles into WAIT aborts the frame
    cur_pred = 3'd1;
    push_exp(44'h11111111111, 3'd1, 1'b0);
    send_frame(44'h11111111111, 1'b0, 1'b0, fe);
    repeat (10) @(posedge clk);
    #3;
    chk("mid_wait_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_rst_features", features, '0);
    chk("async_rst_m_valid", m_valid, 1'b0);
    chk("async_rst_s_ready", s_ready, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cur_pred = 3'd2;
    push_exp(44'hFFFFFFFFFFF, 3'd2, 1'b0);
    send_frame(44'hFFFFFFFFFFF, 1'b0, 1'b0, fe);
    wait_idle();

    // Back-to-back frames with m_ready tied high
    pulses = 0;
    hi_cycles = 0;
    cur_pred = 3'd4;
    push_exp(44'h0123456789A, 3'd4, 1'b0);
    send_frame(44'h0123456789A, 1'b0, 1'b0, fe);
    cur_pred = 3'd0;
    push_exp(44'h3C3C3C3C3C3, 3'd0, 1'b0);
    send_frame(44'h3C3C3C3C3C3, 1'b0, 1'b0, fb);
    chk("b2b_first_beat_after_hs", fb, hs_edge + 1);
    wait_idle();
    chk("b2b_pulses", pulses, 2);
    chk("b2b_high_cycles", hi_cycles, 2);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
